// File: rtl/alarm_controller_if.sv
`default_nettype none
// ============================================================================
// Module      : alarm_controller_if
// Description : Time-of-day, alarm programming and control bundle for the
//               alarm stage downstream of the digital clock counter.
// Revision    : 1.0
// ============================================================================
interface alarm_controller_if;
    logic [4:0] hours;
    logic [5:0] minutes;
    logic [5:0] seconds;
    logic       set_alarm;
    logic [4:0] alarm_hours_in;
    logic [5:0] alarm_minutes_in;
    logic       alarm_enable;
    logic       snooze;
    logic       stop;
    logic       alarm_on;
    logic       snoozing;
    logic [1:0] snooze_count;
    logic [4:0] alarm_hours;
    logic [5:0] alarm_minutes;
    logic       set_err;

    modport master (
        output hours, minutes, seconds, set_alarm, alarm_hours_in,
               alarm_minutes_in, alarm_enable, snooze, stop,
        input  alarm_on, snoozing, snooze_count, alarm_hours, alarm_minutes,
               set_err
    );

    modport slave (
        input  hours, minutes, seconds, set_alarm, alarm_hours_in,
               alarm_minutes_in, alarm_enable, snooze, stop,
        output alarm_on, snoozing, snooze_count, alarm_hours, alarm_minutes,
               set_err
    );
endinterface
`default_nettype wire

// File: rtl/alarm_controller.sv
`default_nettype none
// ============================================================================
// Module      : alarm_controller
// Description : Programmable alarm with timed ring-out, stop and bounded snooze.
// Revision    : 1.0
// ============================================================================
module alarm_controller #(
    parameter int RING_SECS   = 60,
    parameter int SNOOZE_SECS = 300,
    parameter int MAX_SNOOZES = 3
) (
    input  wire logic          Clk_1sec,
    input  wire logic          reset,
    alarm_controller_if.slave  bus
);
    // One-hot-style encoding so each status output is a flop bit directly
    localparam logic [1:0] c_IDLE    = 2'b00;
    localparam logic [1:0] c_RINGING = 2'b01;
    localparam logic [1:0] c_SNOOZE  = 2'b10;

    localparam logic [8:0] c_RING_LOAD   = 9'(RING_SECS - 1);
    localparam logic [8:0] c_SNOOZE_LOAD = 9'(SNOOZE_SECS - 1);
    localparam logic [1:0] c_MAX_SNOOZES = 2'(MAX_SNOOZES);

    logic [1:0] r_state,         w_state_nxt;
    logic [8:0] r_ring_cnt,      w_ring_cnt_nxt;
    logic [8:0] r_snz_cnt,       w_snz_cnt_nxt;
    logic [1:0] r_snooze_count,  w_snooze_count_nxt;
    logic [4:0] r_alarm_hours,   w_alarm_hours_nxt;
    logic [5:0] r_alarm_minutes, w_alarm_minutes_nxt;
    logic       r_set_err,       w_set_err_nxt;
    logic       w_set_valid;
    logic       w_match;

    always_ff @(posedge Clk_1sec) begin
        if (reset) begin
            r_state         <= c_IDLE;
            r_ring_cnt      <= '0;
            r_snz_cnt       <= '0;
            r_snooze_count  <= '0;
            r_alarm_hours   <= '0;
            r_alarm_minutes <= '0;
            r_set_err       <= 1'b0;
        end else begin
            r_state         <= w_state_nxt;
            r_ring_cnt      <= w_ring_cnt_nxt;
            r_snz_cnt       <= w_snz_cnt_nxt;
            r_snooze_count  <= w_snooze_count_nxt;
            r_alarm_hours   <= w_alarm_hours_nxt;
            r_alarm_minutes <= w_alarm_minutes_nxt;
            r_set_err       <= w_set_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt         = r_state;
        w_ring_cnt_nxt      = r_ring_cnt;
        w_snz_cnt_nxt       = r_snz_cnt;
        w_snooze_count_nxt  = r_snooze_count;
        w_alarm_hours_nxt   = r_alarm_hours;
        w_alarm_minutes_nxt = r_alarm_minutes;
        w_set_err_nxt       = 1'b0;
        w_set_valid = (bus.alarm_hours_in <= 5'd23) && (bus.alarm_minutes_in <= 6'd59);
        w_match     = (bus.hours == r_alarm_hours) && (bus.minutes == r_alarm_minutes)
                   && (bus.seconds == 6'd0);

        if (bus.set_alarm && w_set_valid) begin
            w_alarm_hours_nxt   = bus.alarm_hours_in;
            w_alarm_minutes_nxt = bus.alarm_minutes_in;
            w_state_nxt         = c_IDLE;
        end else begin
            // A rejected load only flags the error; the FSM carries on normally
            w_set_err_nxt = bus.set_alarm;
            if (!bus.alarm_enable || bus.stop) begin
                w_state_nxt = c_IDLE;
            end else begin
                case (r_state)
                    c_IDLE: begin
                        if (w_match) begin
                            w_state_nxt    = c_RINGING;
                            w_ring_cnt_nxt = c_RING_LOAD;
                        end
                    end
                    c_RINGING: begin
                        if (bus.snooze && (r_snooze_count < c_MAX_SNOOZES)) begin
                            w_state_nxt        = c_SNOOZE;
                            w_snooze_count_nxt = r_snooze_count + 2'd1;
                            w_snz_cnt_nxt      = c_SNOOZE_LOAD;
                        end else if (r_ring_cnt == 9'd0) begin
                            w_state_nxt = c_IDLE;
                        end else begin
                            w_ring_cnt_nxt = r_ring_cnt - 9'd1;
                        end
                    end
                    c_SNOOZE: begin
                        if (r_snz_cnt == 9'd0) begin
                            w_state_nxt    = c_RINGING;
                            w_ring_cnt_nxt = c_RING_LOAD;
                        end else begin
                            w_snz_cnt_nxt = r_snz_cnt - 9'd1;
                        end
                    end
                    default: w_state_nxt = c_IDLE;
                endcase
            end
        end

        if (w_state_nxt == c_IDLE) begin
            w_snooze_count_nxt = 2'd0;
        end
    end

    always_comb begin
        bus.alarm_on      = r_state[0];
        bus.snoozing      = r_state[1];
        bus.snooze_count  = r_snooze_count;
        bus.alarm_hours   = r_alarm_hours;
        bus.alarm_minutes = r_alarm_minutes;
        bus.set_err       = r_set_err;
    end
endmodule
`default_nettype wire
